// File: rtl/gcd_pkg.sv
// Shared types and constants for the GCD core.
package gcd_pkg;

    localparam int unsigned GCD_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } gcd_state_e;

endpackage

// File: rtl/gcd_step.sv
// One subtractive-GCD step: compares A and B and forms the larger-minus-smaller update.
module gcd_step
    import gcd_pkg::*;
#(
    parameter int unsigned WIDTH = GCD_DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             eq,
    output logic             a_gt_b,
    output logic [WIDTH-1:0] a_next,
    output logic [WIDTH-1:0] b_next
);

    always_comb begin
        eq     = (a == b);
        a_gt_b = (a > b);
        a_next = a;
        b_next = b;
        if (a_gt_b) begin
            a_next = a - b;
        end else if (!eq) begin
            b_next = b - a;
        end
    end

endmodule

// File: rtl/gcd_core.sv
// Handshaked subtractive GCD engine (IDLE/CALC/DONE).
// Optional macro GCD_CORE_CYCLE_CNT_EN adds the cycles_o CALC-cycle counter output.
module gcd_core
    import gcd_pkg::*;
#(
    parameter int unsigned WIDTH = GCD_DEFAULT_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o
`ifdef GCD_CORE_CYCLE_CNT_EN
    ,
    output logic [WIDTH-1:0] cycles_o
`endif
);

    gcd_state_e       state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             ready_q;
    logic             valid_q;

    logic             eq;
    logic             a_gt_b;
    logic [WIDTH-1:0] a_next;
    logic [WIDTH-1:0] b_next;
    logic             accept;
    logic             calc_zero;

    gcd_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .a      (a_q),
        .b      (b_q),
        .eq     (eq),
        .a_gt_b (a_gt_b),
        .a_next (a_next),
        .b_next (b_next)
    );

    assign accept    = valid_i && ready_q;
    // A or B can only be zero in CALC when a zero operand was accepted.
    assign calc_zero = (a_q == '0) || (b_q == '0);

    // Zero operands pass through CALC once so their latency matches the single-step case.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q     <= a_i;
                        b_q     <= b_i;
                        ready_q <= 1'b0;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    if (calc_zero) begin
                        result_q <= '0;
                        zero_q   <= 1'b1;
                        valid_q  <= 1'b1;
                        state_q  <= DONE;
                    end else if (eq) begin
                        result_q <= a_q;
                        zero_q   <= 1'b0;
                        valid_q  <= 1'b1;
                        state_q  <= DONE;
                    end else if (a_gt_b) begin
                        a_q <= a_next;
                    end else begin
                        b_q <= b_next;
                    end
                end
                DONE: begin
                    if (ready_i) begin
                        result_q <= '0;
                        zero_q   <= 1'b0;
                        valid_q  <= 1'b0;
                        ready_q  <= 1'b1;
                        state_q  <= IDLE;
                    end
                end
                default: begin
                    result_q <= '0;
                    zero_q   <= 1'b0;
                    valid_q  <= 1'b0;
                    ready_q  <= 1'b1;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign ready_o  = ready_q;
    assign valid_o  = valid_q;
    assign result_o = result_q;
    assign zero_o   = zero_q;

`ifdef GCD_CORE_CYCLE_CNT_EN
    logic [WIDTH-1:0] cnt_q;

    // Worst case (2^WIDTH-1, 1) takes exactly 2^WIDTH-1 CALC cycles, so no wrap.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= '0;
        end else if (state_q == CALC && !calc_zero) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cycles_o = valid_q ? cnt_q : '0;
`else
    // Cycle counter not built in this configuration.
`endif

endmodule

// File: tb/tb_gcd_core.sv
// Self-checking bench for gcd_core: directed table, handshake/reset corners, random vs. Euclid model.
module tb_gcd_core;

    localparam int unsigned W = 8;

    logic         clk_i;
    logic         rst_ni;
    logic         valid_i;
    logic         ready_o;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         valid_o;
    logic         ready_i;
    logic [W-1:0] result_o;
    logic         zero_o;
`ifdef GCD_CORE_CYCLE_CNT_EN
    logic [W-1:0] cycles_o;
`endif

    int n_checks;
    int n_fail;

    gcd_core #(
        .WIDTH (W)
    ) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .a_i      (a_i),
        .b_i      (b_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .result_o (result_o),
        .zero_o   (zero_o)
`ifdef GCD_CORE_CYCLE_CNT_EN
        ,
        .cycles_o (cycles_o)
`endif
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: Euclid by division. The subtractive engine spends q CALC cycles per
    // quotient q (q-1 subtractions plus the final equality/handover), so cycles = sum(q).
    task automatic ref_gcd(input int a, input int b, output int res, output int zero,
                           output int lat, output int cyc);
        int x, y, t, sum;
        if (a == 0 || b == 0) begin
            res = 0; zero = 1; lat = 1; cyc = 0;
        end else begin
            x = (a > b) ? a : b;
            y = (a > b) ? b : a;
            sum = 0;
            while (y != 0) begin
                sum += x / y;
                t = x % y;
                x = y;
                y = t;
            end
            res = x; zero = 0; lat = sum; cyc = sum;
        end
    endtask

    task automatic start_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk_i);
        a_i     = a;
        b_i     = b;
        valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        a_i     = W'($urandom);
        b_i     = W'($urandom);
        check({tag, " ready_o after accept"}, 32'(ready_o), 32'd0);
    endtask

    // Counts edges after the accept edge until valid_o; also checks result/zero stay 0 meanwhile.
    task automatic wait_done(input string tag, output int lat);
        bit leak;
        lat  = 0;
        leak = 1'b0;
        do begin
            @(posedge clk_i);
            #1;
            lat++;
            if (!valid_o && (result_o != '0 || zero_o != 1'b0)) leak = 1'b1;
        end while (!valid_o && lat < 600);
        check({tag, " outputs zero while busy"}, 32'(leak), 32'd0);
        check({tag, " valid_o within budget"}, 32'(valid_o), 32'd1);
    endtask

    task automatic check_result(input string tag, input int lat, input int exp_res,
                                input int exp_zero, input int exp_lat, input int exp_cyc);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " result_o"}, 32'(result_o), 32'(exp_res));
        check({tag, " zero_o"}, 32'(zero_o), 32'(exp_zero));
        check({tag, " ready_o in DONE"}, 32'(ready_o), 32'd0);
`ifdef GCD_CORE_CYCLE_CNT_EN
        check({tag, " cycles_o"}, 32'(cycles_o), 32'(exp_cyc));
`else
        if (exp_cyc < 0) $display("note: negative cycle expectation for %s", tag);
`endif
    endtask

    task automatic consume(input string tag);
        @(negedge clk_i);
        ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        ready_i = 1'b0;
        check({tag, " ready_o after consume"}, 32'(ready_o), 32'd1);
        check({tag, " valid_o after consume"}, 32'(valid_o), 32'd0);
        check({tag, " result_o after consume"}, 32'(result_o), 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int exp_res, input int exp_zero, input int exp_lat,
                          input int exp_cyc);
        int lat;
        start_op(tag, a, b);
        wait_done(tag, lat);
        check_result(tag, lat, exp_res, exp_zero, exp_lat, exp_cyc);
        consume(tag);
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           res;
        int           zero;
        int           lat;
        int           cyc;
    } vec_t;

    vec_t vecs[13];

    initial begin
        int lat;
        int r_res, r_zero, r_lat, r_cyc;
        logic [W-1:0] ra, rb;

        vecs[0]  = '{8'd12,  8'd18,  6,  0, 3,   3};
        vecs[1]  = '{8'd18,  8'd12,  6,  0, 3,   3};
        vecs[2]  = '{8'd7,   8'd7,   7,  0, 1,   1};
        vecs[3]  = '{8'd0,   8'd5,   0,  1, 1,   0};
        vecs[4]  = '{8'd5,   8'd0,   0,  1, 1,   0};
        vecs[5]  = '{8'd0,   8'd0,   0,  1, 1,   0};
        vecs[6]  = '{8'd255, 8'd1,   1,  0, 255, 255};
        vecs[7]  = '{8'd1,   8'd255, 1,  0, 255, 255};
        vecs[8]  = '{8'd254, 8'd255, 1,  0, 255, 255};
        vecs[9]  = '{8'd128, 8'd64,  64, 0, 2,   2};
        vecs[10] = '{8'd1,   8'd1,   1,  0, 1,   1};
        vecs[11] = '{8'd100, 8'd75,  25, 0, 4,   4};
        vecs[12] = '{8'd9,   8'd6,   3,  0, 3,   3};

        n_checks = 0;
        n_fail   = 0;
        rst_ni   = 1'b0;
        valid_i  = 1'b0;
        ready_i  = 1'b0;
        a_i      = '0;
        b_i      = '0;

        #12;
        check("reset ready_o", 32'(ready_o), 32'd1);
        check("reset valid_o", 32'(valid_o), 32'd0);
        check("reset result_o", 32'(result_o), 32'd0);
        check("reset zero_o", 32'(zero_o), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        for (int i = 0; i < 13; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].res,
                   vecs[i].zero, vecs[i].lat, vecs[i].cyc);
        end

        // Back-pressure in DONE with competing operands on the input side.
        start_op("hold", 8'd12, 8'd18);
        wait_done("hold", lat);
        check_result("hold", lat, 6, 0, 3, 3);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_i);
            valid_i = 1'b1;
            a_i     = 8'd9;
            b_i     = 8'd6;
            @(posedge clk_i);
            #1;
            check($sformatf("hold%0d valid_o", k), 32'(valid_o), 32'd1);
            check($sformatf("hold%0d result_o", k), 32'(result_o), 32'd6);
            check($sformatf("hold%0d ready_o", k), 32'(ready_o), 32'd0);
        end
        @(negedge clk_i);
        ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        ready_i = 1'b0;
        check("release ready_o (no same-cycle accept)", 32'(ready_o), 32'd1);
        check("release valid_o", 32'(valid_o), 32'd0);
        run_op("after_hold", 8'd9, 8'd6, 3, 0, 3, 3);

        // Reset in the middle of CALC.
        start_op("rst_calc", 8'd12, 8'd18);
        @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        check("rst_calc ready_o", 32'(ready_o), 32'd1);
        check("rst_calc valid_o", 32'(valid_o), 32'd0);
        check("rst_calc result_o", 32'(result_o), 32'd0);
        check("rst_calc zero_o", 32'(zero_o), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        run_op("post_rst", 8'd9, 8'd6, 3, 0, 3, 3);

        // Reset while a result is waiting in DONE.
        start_op("rst_done", 8'd0, 8'd3);
        wait_done("rst_done", lat);
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        check("rst_done valid_o", 32'(valid_o), 32'd0);
        check("rst_done zero_o", 32'(zero_o), 32'd0);
        check("rst_done ready_o", 32'(ready_o), 32'd1);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Random operands against the Euclid model.
        for (int i = 0; i < 40; i++) begin
            ra = ($urandom_range(0, 9) == 0) ? '0 : W'($urandom_range(1, 255));
            rb = ($urandom_range(0, 9) == 0) ? '0 : W'($urandom_range(1, 255));
            if (i % 4 == 0) begin
                ra = W'($urandom_range(1, 16) * 6);
                rb = W'($urandom_range(1, 16) * 4);
            end
            ref_gcd(int'(ra), int'(rb), r_res, r_zero, r_lat, r_cyc);
            run_op($sformatf("rnd%0d(%0d,%0d)", i, ra, rb), ra, rb, r_res, r_zero, r_lat, r_cyc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
